// File: rtl/snake_frame_renderer_pkg.sv
// rtl/snake_frame_renderer_pkg.sv - shared defaults, colours and FSM encoding for the snake frame renderer
package snake_frame_renderer_pkg;

    localparam int SCREEN_W_DEF = 240;
    localparam int SCREEN_H_DEF = 320;
    localparam int XW_DEF       = 8;
    localparam int YW_DEF       = 9;
    localparam int MAX_SEGS_DEF = 128;
    localparam int LW_DEF       = 8;
    localparam int SEG_SIZE_DEF = 10;

    localparam logic [15:0] BG_COL    = 16'h0000;
    localparam logic [15:0] BODY_COL  = 16'h07E0;
    localparam logic [15:0] HEAD_COL  = 16'hFFE0;
    localparam logic [15:0] APPLE_COL = 16'hF800;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Head beats body beats apple beats background.
    function automatic logic [15:0] pick_colour(input logic head, input logic body, input logic apple);
        if (head)       return HEAD_COL;
        else if (body)  return BODY_COL;
        else if (apple) return APPLE_COL;
        else            return BG_COL;
    endfunction

endpackage

// File: rtl/snake_frame_renderer_if.sv
// rtl/snake_frame_renderer_if.sv - LT24 pixel-write port with valid/ready handshake
interface snake_frame_renderer_if #(
    parameter int XW = 8,
    parameter int YW = 9
);
    logic [XW-1:0] pixelX;
    logic [YW-1:0] pixelY;
    logic [15:0]   pixelData;
    logic          pixelWrite;
    logic          pixelReady;

    modport master (output pixelX, output pixelY, output pixelData, output pixelWrite, input pixelReady);
    modport slave  (input pixelX, input pixelY, input pixelData, input pixelWrite, output pixelReady);
endinterface

// File: rtl/snake_frame_renderer_seg_box_hit.sv
// rtl/snake_frame_renderer_seg_box_hit.sv - tests whether a pixel lies inside one SEG_SIZE square box
module seg_box_hit #(
    parameter int XW       = 8,
    parameter int YW       = 9,
    parameter int SEG_SIZE = 10
) (
    input  logic [XW-1:0] px,
    input  logic [YW-1:0] py,
    input  logic [XW-1:0] ox,
    input  logic [YW-1:0] oy,
    input  logic          enable,
    output logic          hit
);
    logic [XW:0] dx;
    logic [YW:0] dy;

    // One extra bit keeps the sign, so boxes past the right/bottom edge clip instead of wrapping.
    always_comb begin
        dx  = {1'b0, px} - {1'b0, ox};
        dy  = {1'b0, py} - {1'b0, oy};
        hit = enable && !dx[XW] && !dy[YW]
              && (dx < (XW+1)'(SEG_SIZE)) && (dy < (YW+1)'(SEG_SIZE));
    end
endmodule

// File: rtl/snake_frame_renderer.sv
// rtl/snake_frame_renderer.sv - snapshots snake/apple positions and streams one raster frame of RGB565
module snake_frame_renderer
    import snake_frame_renderer_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int XW       = XW_DEF,
    parameter int YW       = YW_DEF,
    parameter int MAX_SEGS = MAX_SEGS_DEF,
    parameter int LW       = LW_DEF,
    parameter int SEG_SIZE = SEG_SIZE_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frameStart,
    input  logic [XW-1:0]          appleX,
    input  logic [YW-1:0]          appleY,
    input  logic [MAX_SEGS*XW-1:0] snakeX,
    input  logic [MAX_SEGS*YW-1:0] snakeY,
    input  logic [LW-1:0]          snakeLength,
    output logic                   frameBusy,
    output logic                   frameDone,
    snake_frame_renderer_if.master pix
);
    state_e state_q, state_d;
    logic   snap, scanning, advance, issue, last_accept;

    logic                   pending_q, pending_d;
    logic [XW-1:0]          apple_x_q, apple_x_d;
    logic [YW-1:0]          apple_y_q, apple_y_d;
    logic [MAX_SEGS*XW-1:0] snake_x_q, snake_x_d;
    logic [MAX_SEGS*YW-1:0] snake_y_q, snake_y_d;
    logic [LW-1:0]          len_q, len_d;
    logic [XW-1:0]          cx_q, cx_d;
    logic [YW-1:0]          cy_q, cy_d;
    logic                   issue_done_q, issue_done_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [XW-1:0]          s1_x_q, s1_x_d;
    logic [YW-1:0]          s1_y_q, s1_y_d;
    logic                   s1_head_q, s1_head_d, s1_body_q, s1_body_d, s1_apple_q, s1_apple_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [XW-1:0]          pixel_x_q, pixel_x_d;
    logic [YW-1:0]          pixel_y_q, pixel_y_d;
    logic [15:0]            pixel_data_q, pixel_data_d;

    logic [XW-1:0] box_x [MAX_SEGS+1];
    logic [YW-1:0] box_y [MAX_SEGS+1];
    logic [MAX_SEGS:0] box_en, hit;

    assign pix.pixelX     = pixel_x_q;
    assign pix.pixelY     = pixel_y_q;
    assign pix.pixelData  = pixel_data_q;
    assign pix.pixelWrite = s2_valid_q;

    assign last_accept = s2_valid_q && pix.pixelReady
                         && (pixel_x_q == XW'(SCREEN_W - 1)) && (pixel_y_q == YW'(SCREEN_H - 1));

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: one snapshot cycle, scan until the last pixel is taken, one done cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (frameStart || pending_q) state_d = ST_SNAP;
            ST_SNAP: state_d = ST_SCAN;
            ST_SCAN: if (last_accept) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        snap      = (state_q == ST_SNAP);
        scanning  = (state_q == ST_SCAN);
        frameBusy = snap || scanning;
        frameDone = (state_q == ST_DONE);
    end

    // Unpack the snapshot into per-box origins; the last box is the apple.
    always_comb begin
        for (int i = 0; i < MAX_SEGS; i++) begin
            box_x[i]  = snake_x_q[i*XW +: XW];
            box_y[i]  = snake_y_q[i*YW +: YW];
            box_en[i] = (int'(len_q) > i);
        end
        box_x[MAX_SEGS]  = apple_x_q;
        box_y[MAX_SEGS]  = apple_y_q;
        box_en[MAX_SEGS] = 1'b1;
    end

    for (genvar g = 0; g <= MAX_SEGS; g++) begin : g_box
        seg_box_hit #(.XW(XW), .YW(YW), .SEG_SIZE(SEG_SIZE)) u_hit (
            .px(cx_q), .py(cy_q), .ox(box_x[g]), .oy(box_y[g]), .enable(box_en[g]), .hit(hit[g])
        );
    end

    // Snapshot, raster counters and the two pipeline stages; both stages move only when stage 2 can drain.
    always_comb begin
        pending_d    = pending_q;
        apple_x_d    = apple_x_q;
        apple_y_d    = apple_y_q;
        snake_x_d    = snake_x_q;
        snake_y_d    = snake_y_q;
        len_d        = len_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        issue_done_d = issue_done_q;
        s1_valid_d   = s1_valid_q;
        s1_x_d       = s1_x_q;
        s1_y_d       = s1_y_q;
        s1_head_d    = s1_head_q;
        s1_body_d    = s1_body_q;
        s1_apple_d   = s1_apple_q;
        s2_valid_d   = s2_valid_q;
        pixel_x_d    = pixel_x_q;
        pixel_y_d    = pixel_y_q;
        pixel_data_d = pixel_data_q;
        advance      = !s2_valid_q || pix.pixelReady;
        issue        = scanning && !issue_done_q;

        if (frameStart && (state_q != ST_IDLE)) pending_d = 1'b1;
        else if (snap)                           pending_d = 1'b0;

        if (snap) begin
            apple_x_d    = appleX;
            apple_y_d    = appleY;
            snake_x_d    = snakeX;
            snake_y_d    = snakeY;
            len_d        = (int'(snakeLength) > MAX_SEGS) ? LW'(MAX_SEGS) : snakeLength;
            cx_d         = '0;
            cy_d         = '0;
            issue_done_d = 1'b0;
            s1_valid_d   = 1'b0;
            s2_valid_d   = 1'b0;
        end else if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                pixel_x_d    = s1_x_q;
                pixel_y_d    = s1_y_q;
                pixel_data_d = pick_colour(s1_head_q, s1_body_q, s1_apple_q);
            end
            s1_valid_d = issue;
            if (issue) begin
                s1_x_d     = cx_q;
                s1_y_d     = cy_q;
                s1_head_d  = hit[0];
                s1_body_d  = |hit[MAX_SEGS-1:1];
                s1_apple_d = hit[MAX_SEGS];
                if (cx_q == XW'(SCREEN_W - 1)) begin
                    cx_d = '0;
                    if (cy_q == YW'(SCREEN_H - 1)) issue_done_d = 1'b1;
                    else                           cy_d = cy_q + 1'b1;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q    <= 1'b0;
            apple_x_q    <= '0;
            apple_y_q    <= '0;
            snake_x_q    <= '0;
            snake_y_q    <= '0;
            len_q        <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            issue_done_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_head_q    <= 1'b0;
            s1_body_q    <= 1'b0;
            s1_apple_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            pixel_x_q    <= '0;
            pixel_y_q    <= '0;
            pixel_data_q <= '0;
        end else begin
            pending_q    <= pending_d;
            apple_x_q    <= apple_x_d;
            apple_y_q    <= apple_y_d;
            snake_x_q    <= snake_x_d;
            snake_y_q    <= snake_y_d;
            len_q        <= len_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            issue_done_q <= issue_done_d;
            s1_valid_q   <= s1_valid_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_head_q    <= s1_head_d;
            s1_body_q    <= s1_body_d;
            s1_apple_q   <= s1_apple_d;
            s2_valid_q   <= s2_valid_d;
            pixel_x_q    <= pixel_x_d;
            pixel_y_q    <= pixel_y_d;
            pixel_data_q <= pixel_data_d;
        end
    end
endmodule

// File: tb/tb_snake_frame_renderer.sv
// tb/tb_snake_frame_renderer.sv - directed self-checking bench for snake_frame_renderer on a small screen
module tb_snake_frame_renderer;
    localparam int W   = 40;
    localparam int H   = 24;
    localparam int XW  = 8;
    localparam int YW  = 9;
    localparam int MS  = 8;
    localparam int LW  = 8;
    localparam int SEG = 10;
    localparam int N   = W * H;

    logic clock = 1'b0;
    logic rst_n;
    logic frame_start;
    logic [XW-1:0] apple_x;
    logic [YW-1:0] apple_y;
    logic [MS*XW-1:0] snake_x;
    logic [MS*YW-1:0] snake_y;
    logic [LW-1:0] snake_length;
    logic frame_busy, frame_done;

    snake_frame_renderer_if #(.XW(XW), .YW(YW)) pif ();

    snake_frame_renderer #(
        .SCREEN_W(W), .SCREEN_H(H), .XW(XW), .YW(YW), .MAX_SEGS(MS), .LW(LW), .SEG_SIZE(SEG)
    ) dut (
        .clock(clock), .reset(rst_n), .frameStart(frame_start),
        .appleX(apple_x), .appleY(apple_y), .snakeX(snake_x), .snakeY(snake_y),
        .snakeLength(snake_length), .frameBusy(frame_busy), .frameDone(frame_done), .pix(pif)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // drive-side and model-side configurations
    int d_ax, d_ay, d_len, m_ax, m_ay, m_len;
    int d_sx [MS];
    int d_sy [MS];
    int m_sx [MS];
    int m_sy [MS];
    bit rand_mode = 0;

    // capture of accepted pixels, latched per completed frame
    logic [XW-1:0] cap_x [N];
    logic [YW-1:0] cap_y [N];
    logic [15:0]   cap_d [N];
    logic [XW-1:0] fr_x [N];
    logic [YW-1:0] fr_y [N];
    logic [15:0]   fr_d [N];
    logic [15:0]   ref_d [N];
    int cap_n = 0, fr_n = 0, done_count = 0, hold_err = 0;
    logic          prev_w = 0, prev_r = 0;
    logic [XW-1:0] prev_x;
    logic [YW-1:0] prev_y;
    logic [15:0]   prev_d;

    always @(negedge clock) begin
        if (!rst_n) begin
            cap_n  = 0;
            prev_w = 0;
        end else begin
            if (prev_w && !prev_r &&
                (!pif.pixelWrite || pif.pixelX != prev_x || pif.pixelY != prev_y || pif.pixelData != prev_d))
                hold_err++;
            prev_w = pif.pixelWrite; prev_r = pif.pixelReady;
            prev_x = pif.pixelX; prev_y = pif.pixelY; prev_d = pif.pixelData;
            if (pif.pixelWrite && pif.pixelReady) begin
                if (cap_n < N) begin
                    cap_x[cap_n] = pif.pixelX;
                    cap_y[cap_n] = pif.pixelY;
                    cap_d[cap_n] = pif.pixelData;
                end
                cap_n++;
            end
            if (frame_done) begin
                fr_x = cap_x; fr_y = cap_y; fr_d = cap_d;
                fr_n = cap_n; cap_n = 0;
                done_count++;
            end
        end
    end

    initial begin
        pif.pixelReady = 1'b1;
        forever begin
            @(posedge clock);
            #1 pif.pixelReady = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic bit in_box(int x, int y, int ox, int oy);
        return x >= ox && x < ox + SEG && y >= oy && y < oy + SEG;
    endfunction

    function automatic logic [15:0] model_col(int x, int y);
        int  ml = (m_len > MS) ? MS : m_len;
        bit  hd = 0, bd = 0;
        for (int i = 0; i < ml; i++)
            if (in_box(x, y, m_sx[i], m_sy[i])) begin
                if (i == 0) hd = 1; else bd = 1;
            end
        if (hd) return 16'hFFE0;
        if (bd) return 16'h07E0;
        if (in_box(x, y, m_ax, m_ay)) return 16'hF800;
        return 16'h0000;
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < MS; i++) begin d_sx[i] = 0; d_sy[i] = 0; end
        d_ax = 0; d_ay = 0; d_len = 0;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < MS; i++) begin
            snake_x[i*XW +: XW] = XW'(d_sx[i]);
            snake_y[i*YW +: YW] = YW'(d_sy[i]);
        end
        apple_x = XW'(d_ax); apple_y = YW'(d_ay); snake_length = LW'(d_len);
    endtask

    task automatic commit_model();
        m_sx = d_sx; m_sy = d_sy; m_ax = d_ax; m_ay = d_ay; m_len = d_len;
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        int cyc = 0;
        while (done_count < target && cyc < 4 * N + 200) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, " done"}, 32'(done_count >= target), 1);
    endtask

    task automatic wait_cap(input string tag, input int target);
        int cyc = 0;
        while (cap_n < target && cyc < 4 * N) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, " reached"}, 32'(cap_n >= target), 1);
    endtask

    task automatic verify_frame(input string tag);
        int oe = 0, ce = 0;
        check({tag, " count"}, fr_n, N);
        for (int i = 0; i < N; i++) begin
            if (fr_x[i] != XW'(i % W) || fr_y[i] != YW'(i / W)) oe++;
            if (fr_d[i] != model_col(i % W, i / W)) ce++;
        end
        check({tag, " order"}, oe, 0);
        check({tag, " colour"}, ce, 0);
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [15:0] exp);
        check(tag, fr_d[y * W + x], exp);
    endtask

    task automatic cfg_main();
        clear_cfg();
        d_sx[0] = 10; d_sy[0] = 5;
        d_sx[1] = 20; d_sy[1] = 5;
        d_sx[2] = 30; d_sy[2] = 5;
        d_ax = 5; d_ay = 14; d_len = 3;
    endtask

    initial begin
        int base, diff;
        rst_n = 1'b0; frame_start = 1'b0;
        clear_cfg(); apply_inputs(); commit_model();
        repeat (3) @(posedge clock);
        #1;
        check("rst pixelWrite", pif.pixelWrite, 0);
        check("rst frameBusy", frame_busy, 0);
        check("rst frameDone", frame_done, 0);
        check("rst pixelData", pif.pixelData, 0);
        @(negedge clock) rst_n = 1'b1;

        // reset in the middle of a scan, then a clean frame from (0,0)
        cfg_main(); apply_inputs(); commit_model();
        pulse_start();
        wait_cap("t1 mid", 500);
        rst_n = 1'b0;
        @(posedge clock); #1;
        check("t1 pixelWrite", pif.pixelWrite, 0);
        check("t1 frameBusy", frame_busy, 0);
        check("t1 frameDone", frame_done, 0);
        @(negedge clock) rst_n = 1'b1;
        repeat (20) @(negedge clock);
        check("t1 idle after reset", frame_busy, 0);
        base = done_count;
        pulse_start();
        wait_done("t1", base + 1);
        verify_frame("t1");
        check("t1 first x", fr_x[0], 0);
        check("t1 first y", fr_y[0], 0);

        // three-segment snake with apple, ready held high
        base = done_count;
        pulse_start();
        @(negedge clock);
        check("t2 busy", frame_busy, 1);
        wait_done("t2", base + 1);
        verify_frame("t2");
        probe("t2 head", 10, 5, 16'hFFE0);
        probe("t2 body", 25, 8, 16'h07E0);
        probe("t2 apple", 7, 16, 16'hF800);
        probe("t2 head over apple", 12, 14, 16'hFFE0);
        probe("t2 body edge", 39, 14, 16'h07E0);
        probe("t2 below body", 39, 15, 16'h0000);
        probe("t2 unused slot", 0, 0, 16'h0000);
        ref_d = fr_d;

        // same frame with random back-pressure
        rand_mode = 1;
        hold_err = 0;
        base = done_count;
        pulse_start();
        wait_done("t3", base + 1);
        rand_mode = 0;
        verify_frame("t3");
        diff = 0;
        for (int i = 0; i < N; i++) if (fr_d[i] != ref_d[i]) diff++;
        check("t3 same as ready run", diff, 0);
        check("t3 stall hold", hold_err, 0);

        // head clipped at the bottom-right corner
        clear_cfg();
        d_sx[0] = 35; d_sy[0] = 19; d_len = 1;
        apply_inputs(); commit_model();
        base = done_count;
        pulse_start();
        wait_done("t4", base + 1);
        verify_frame("t4");
        probe("t4 corner", 39, 23, 16'hFFE0);
        probe("t4 origin", 35, 19, 16'hFFE0);
        probe("t4 left of head", 34, 19, 16'h0000);
        probe("t4 no wrap", 0, 20, 16'h0000);

        // requests during a scan merge into exactly one further frame, using the new inputs
        clear_cfg();
        d_len = 1; d_ax = 20; d_ay = 10;
        apply_inputs(); commit_model();
        base = done_count;
        pulse_start();
        wait_cap("t5 mid", 100);
        clear_cfg();
        d_sx[0] = 30; d_sy[0] = 12; d_sx[1] = 20; d_sy[1] = 12;
        d_ax = 2; d_ay = 2; d_len = 2;
        apply_inputs();
        pulse_start();
        repeat (5) @(posedge clock);
        pulse_start();
        wait_done("t5a", base + 1);
        verify_frame("t5a");
        commit_model();
        wait_done("t5b", base + 2);
        verify_frame("t5b");
        repeat (3 * N) @(negedge clock);
        check("t5 frame count", done_count - base, 2);
        check("t5 idle", frame_busy, 0);

        // zero length draws no snake
        clear_cfg();
        d_sx[0] = 5; d_sy[0] = 5; d_ax = 5; d_ay = 5; d_len = 0;
        apply_inputs(); commit_model();
        base = done_count;
        pulse_start();
        wait_done("t6a", base + 1);
        verify_frame("t6a");
        probe("t6a apple only", 5, 5, 16'hF800);

        // oversize length clamps to all slots; head wins over apple, body over apple
        clear_cfg();
        d_sx[0] = 0; d_sy[0] = 0;
        for (int i = 1; i < MS; i++) begin d_sx[i] = 4 * i; d_sy[i] = 12; end
        d_ax = 3; d_ay = 3; d_len = 200;
        apply_inputs(); commit_model();
        base = done_count;
        pulse_start();
        wait_done("t6b", base + 1);
        verify_frame("t6b");
        probe("t6b head over apple", 3, 3, 16'hFFE0);
        probe("t6b apple", 12, 5, 16'hF800);
        probe("t6b body over apple", 12, 12, 16'h07E0);
        probe("t6b last slot", 37, 21, 16'h07E0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
